// File: rtl/memcpy_pkg.sv
// Shared types and encodings for the memcpy sequencer.
package memcpy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LATCH = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Load/store width encodings shared with the datapath controls.
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/memcpy_step.sv
// Element chooser: picks word or byte for the next transfer and forms
// the source/destination element addresses. Purely combinational.
module memcpy_step
  import memcpy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 7
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  rem,
  input  logic              backward,
  input  logic              byte_only,
  output logic [LEN_W-1:0]  size,
  output logic [ADDR_W-1:0] src_elem_addr,
  output logic [ADDR_W-1:0] dst_elem_addr
);

  logic [LEN_W-1:0] fwd_off;
  logic [LEN_W-1:0] word_off;
  logic [LEN_W-1:0] byte_off;
  logic [LEN_W-1:0] off;
  logic [1:0]       src_lo;
  logic [1:0]       dst_lo;
  logic             use_word;

  // Backward copies walk from the top; a word there starts 4 bytes below rem.
  always_comb begin
    fwd_off       = len - rem;
    word_off      = backward ? rem - LEN_W'(WORD_BYTES) : fwd_off;
    byte_off      = backward ? rem - LEN_W'(1) : fwd_off;
    src_lo        = src[1:0] + word_off[1:0];
    dst_lo        = dst[1:0] + word_off[1:0];
    use_word      = !byte_only && (rem >= LEN_W'(WORD_BYTES)) &&
                    (src_lo == 2'b00) && (dst_lo == 2'b00);
    off           = use_word ? word_off : byte_off;
    size          = use_word ? LEN_W'(WORD_BYTES) : LEN_W'(1);
    src_elem_addr = src + ADDR_W'(off);
    dst_elem_addr = dst + ADDR_W'(off);
  end

endmodule

// File: rtl/memcpy_engine.sv
// Multi-cycle memmove sequencer driving the data-memory port.
// Each element costs LOAD (read), LATCH (capture data), STORE (write).
module memcpy_engine
  import memcpy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              byte_only,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_ls_type,
  output logic              mem_load_unsigned,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  logic [ADDR_W-1:0] src_q, dst_q, dst_elem_q;
  logic [LEN_W-1:0]  len_q, rem_q, size_q;
  logic              bwd_q, bo_q;
  logic [DATA_W-1:0] latch_q;

  logic              idle;
  logic              bwd_in;
  logic [LEN_W-1:0]  rem_next;
  logic [ADDR_W-1:0] s_src, s_dst;
  logic [LEN_W-1:0]  s_len, s_rem;
  logic              s_bwd, s_bo;
  logic [LEN_W-1:0]  step_size;
  logic [ADDR_W-1:0] step_src, step_dst;
  logic [1:0]        step_ls;

  assign mem_load_unsigned = 1'b1;
  assign mem_write_data    = latch_q;

  // The chooser looks at the element that the next LOAD will issue: from the
  // ports when starting, from the post-STORE remainder otherwise.
  always_comb begin
    idle     = (state == IDLE);
    bwd_in   = ({1'b0, dst_addr} > {1'b0, src_addr}) &&
               ({1'b0, dst_addr} < ({1'b0, src_addr} + (ADDR_W+1)'(len)));
    rem_next = rem_q - size_q;
    s_src    = idle ? src_addr  : src_q;
    s_dst    = idle ? dst_addr  : dst_q;
    s_len    = idle ? len       : len_q;
    s_rem    = idle ? len       : rem_next;
    s_bwd    = idle ? bwd_in    : bwd_q;
    s_bo     = idle ? byte_only : bo_q;
    step_ls  = (step_size == LEN_W'(WORD_BYTES)) ? LS_WORD : LS_BYTE;
  end

  memcpy_step #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_step (
    .src           (s_src),
    .dst           (s_dst),
    .len           (s_len),
    .rem           (s_rem),
    .backward      (s_bwd),
    .byte_only     (s_bo),
    .size          (step_size),
    .src_elem_addr (step_src),
    .dst_elem_addr (step_dst)
  );

  // Sequencer with registered port outputs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      count_out   <= '0;
      mem_addr    <= '0;
      mem_ls_type <= LS_BYTE;
      latch_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      dst_elem_q  <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      size_q      <= '0;
      bwd_q       <= 1'b0;
      bo_q        <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count_out <= '0;
          if (len != '0) begin
            src_q       <= src_addr;
            dst_q       <= dst_addr;
            len_q       <= len;
            rem_q       <= len;
            bwd_q       <= bwd_in;
            bo_q        <= byte_only;
            size_q      <= step_size;
            dst_elem_q  <= step_dst;
            mem_addr    <= step_src;
            mem_ls_type <= step_ls;
            mem_read    <= 1'b1;
            busy        <= 1'b1;
            state       <= LOAD;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        LOAD: state <= LATCH;
        LATCH: begin
          latch_q   <= mem_read_data;
          mem_addr  <= dst_elem_q;
          mem_write <= 1'b1;
          state     <= STORE;
        end
        STORE: begin
          rem_q     <= rem_next;
          count_out <= count_out + size_q;
          if (rem_next == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            size_q      <= step_size;
            dst_elem_q  <= step_dst;
            mem_addr    <= step_src;
            mem_ls_type <= step_ls;
            mem_read    <= 1'b1;
            state       <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memcpy_engine.md
Name: memcpy_engine

Overview:
- Parametrised multi-cycle copy sequencer for the data-memory port; successor to the single-counter memcpy support in the datapath.
- Copies a block of `len` bytes from `src_addr` to `dst_addr`. Uses word transfers when alignment allows and byte transfers otherwise.
- Handles overlapping regions with a backward copy (memmove semantics).
- Sits beside `data_memory`; the datapath muxes the memory port to this block while `busy`. `done` replaces `counter_done` for releasing `stay`.

Parameters:
- ADDR_W, 32, address width of `src_addr`, `dst_addr` and `mem_addr`.
- LEN_W, 7, width of `len` and `count_out`; maximum copy is 2^LEN_W-1 bytes.
- DATA_W, 32, memory data width; fixed at 32 in this generation, where a word is 4 bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- src_addr  in  ADDR_W  source base byte address; captured on accepted start.
- dst_addr  in  ADDR_W  destination base byte address; captured on accepted start.
- len  in  LEN_W  byte count; captured on accepted start.
- byte_only  in  1  1 = force byte transfers; captured on accepted start.
- busy  out  1  high in LOAD, LATCH and STORE.
- done  out  1  one-cycle pulse when the copy completes.
- count_out  out  LEN_W  bytes copied so far; holds its final value until the next accepted start.
- mem_addr  out  ADDR_W  memory byte address.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_ls_type  out  2  shared LS_BYTE or LS_WORD encoding.
- mem_load_unsigned  out  1  constant 1.
- mem_write_data  out  DATA_W  latched read data; bytes in [7:0].
- mem_read_data  in  DATA_W  valid the cycle after mem_read (1-cycle read latency).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, mem_read, mem_write = 0; count_out=0; mem_addr=0; mem_ls_type=LS_BYTE; data latch=0. Reset mid-copy aborts immediately; bytes already written remain in memory.
- FSM states: IDLE, LOAD, LATCH, STORE, DONE.
- IDLE, start=1, len!=0: capture the operands. Direction is backward when dst>src and dst<src+len (ADDR_W+1-bit compare); otherwise forward. rem=len. Next state LOAD.
- IDLE, start=1, len=0: go to DONE with no memory access.
- start while not in IDLE is ignored.
- Element choice (combinational, each LOAD):
  - Forward: address offset off = len-rem.
  - Backward: off = rem-size, where the word check uses off = rem-4.
  - Word if !byte_only, rem>=4, (src+off)[1:0]==0 and (dst+off)[1:0]==0. Otherwise byte.
  - size = 4 or 1. Element choice is registered for use in LATCH and STORE.
- LOAD: mem_read=1, mem_addr=src+off, mem_ls_type=chosen. Next state LATCH.
- LATCH: latch mem_read_data. Next state STORE.
- STORE: mem_write=1, mem_addr=dst+off, mem_write_data=latch. Update rem-=size and count_out+=size. If rem becomes 0, go to DONE; else go to LOAD.
- DONE: done=1, busy=0. Next state IDLE. start is not accepted in DONE.
- mem_read and mem_write are never high together; both are 0 outside LOAD and STORE.
- Cost is 3 cycles per element. Accepted start at edge t0 gives busy from t0+1, and done in cycle t0+1+3·n_elements.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of memory is not flagged.

Decomposition:
- memcpy_pkg holds:
  - state enum.
  - LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10, matching the controls encodings.
  - WORD_BYTES=4.
- Sub-module memcpy_step: purely combinational. Inputs are src, dst, len, rem, backward and byte_only; outputs are size, src_elem_addr and dst_elem_addr.
- The FSM, counters and latch stay in memcpy_engine.

Test Plan:
1. src=0x100, dst=0x200, len=8, byte_only=0 → 2 word elements; reads at 0x100 then 0x104; done in cycle t0+7; count_out=8; dst bytes equal src.
2. src=0x103, dst=0x203, len=9 → byte at 0x103, word at 0x104, word at 0x108; done at t0+10; count_out=9.
3. src=0x101, dst=0x202, len=6 → 6 byte elements (misaligned pair); done at t0+19; copy correct.
4. src=0x100, dst=0x102, len=8 (overlap) → backward; first read at 0x107, all bytes; dst region equals original src bytes, src bytes 0x100–0x101 unchanged.
5. len=0 with start → done at t0+1; busy never high; no mem_read or mem_write.
6. byte_only=1 aligned len=4 → 4 byte elements. Second start during busy is ignored. rst asserted in STORE of element 2 → next cycle state IDLE, all strobes 0, count_out=0.
